// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: shared encodings and field widths for the ID/EX pipeline register
package id_ex_stage_reg_pkg;
  localparam int REG_W = 5;
  localparam int ALUOP_W = 4;
  typedef enum logic [1:0] {
    REGDST_RT      = 2'd0,
    REGDST_RD      = 2'd1,
    REGDST_RA      = 2'd2,
    REGDST_ILLEGAL = 2'd3
  } regdst_e;
  typedef enum logic [1:0] {
    MEMTOREG_ALU  = 2'd0,
    MEMTOREG_MEM  = 2'd1,
    MEMTOREG_PC4  = 2'd2,
    MEMTOREG_RSVD = 2'd3
  } memtoreg_e;
  typedef struct packed {
    logic               valid;
    regdst_e            regdst;
    memtoreg_e          memtoreg;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
  } ctrl_t;
endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// hazard_detect: combinational load-use detector between the EX load and the ID consumer
// ports: ex_valid_i/ex_mem_read_i/ex_rt_i describe the EX instruction,
//        id_valid_i/id_rs_i/id_rt_i the ID instruction, hazard_o flags a load-use pair
module hazard_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             hazard_o
);
  assign hazard_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) & id_valid_i &
                    ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble, flush, hold and illegal-RegDst trap
// ports: Clk/Reset (sync, active-high); Id* decoded fields in, Ex* registered copies out;
//        Flush kills the ID instruction, ExtStall holds EX; Stall freezes PC and IF/ID;
//        IllegalSticky latches an illegal RegDst; StallCount counts stall cycles, saturating
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               IdValid,
  input  logic [1:0]         IdRegDst,
  input  logic [1:0]         IdMemToReg,
  input  logic               IdRegWrite,
  input  logic               IdMemRead,
  input  logic               IdMemWrite,
  input  logic               IdALUSrc,
  input  logic [ALUOP_W-1:0] IdALUOp,
  input  logic [REG_W-1:0]   IdRs,
  input  logic [REG_W-1:0]   IdRt,
  input  logic [REG_W-1:0]   IdRd,
  input  logic [DATA_W-1:0]  IdRD1,
  input  logic [DATA_W-1:0]  IdRD2,
  input  logic [DATA_W-1:0]  IdImm,
  input  logic [DATA_W-1:0]  IdPCPlus4,
  input  logic               Flush,
  input  logic               ExtStall,
  output logic               ExValid,
  output logic [1:0]         ExRegDst,
  output logic [1:0]         ExMemToReg,
  output logic               ExRegWrite,
  output logic               ExMemRead,
  output logic               ExMemWrite,
  output logic               ExALUSrc,
  output logic [ALUOP_W-1:0] ExALUOp,
  output logic [REG_W-1:0]   ExRs,
  output logic [REG_W-1:0]   ExRt,
  output logic [REG_W-1:0]   ExRd,
  output logic [DATA_W-1:0]  ExRD1,
  output logic [DATA_W-1:0]  ExRD2,
  output logic [DATA_W-1:0]  ExImm,
  output logic [DATA_W-1:0]  ExPCPlus4,
  output logic               Stall,
  output logic               IllegalSticky,
  output logic [CNT_W-1:0]   StallCount
);
  ctrl_t ctrl_q, ctrl_d, id_ctrl;
  logic [4*DATA_W-1:0] data_q, data_d;
  logic sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic hazard, hold, illegal, bubble;
  hazard_detect u_hazard (
    .ex_valid_i   (ctrl_q.valid),
    .ex_mem_read_i(ctrl_q.memread),
    .ex_rt_i      (ctrl_q.rt),
    .id_valid_i   (IdValid),
    .id_rs_i      (IdRs),
    .id_rt_i      (IdRt),
    .hazard_o     (hazard)
  );
  assign id_ctrl = '{valid: IdValid, regdst: regdst_e'(IdRegDst), memtoreg: memtoreg_e'(IdMemToReg),
                     regwrite: IdRegWrite, memread: IdMemRead, memwrite: IdMemWrite,
                     alusrc: IdALUSrc, aluop: IdALUOp, rs: IdRs, rt: IdRt, rd: IdRd};
  always_comb begin
    hold     = ~Flush & ExtStall;
    Stall    = hazard & ~Flush & ~ExtStall;
    // an illegal RegDst is only trapped when the instruction would otherwise be loaded
    illegal  = ~Flush & ~ExtStall & ~hazard & IdValid & (IdRegDst == REGDST_ILLEGAL);
    bubble   = Flush | Stall | illegal | ~IdValid;
    ctrl_d   = hold ? ctrl_q : bubble ? '0 : id_ctrl;
    data_d   = hold ? data_q : bubble ? '0 : {IdRD1, IdRD2, IdImm, IdPCPlus4};
    sticky_d = sticky_q | illegal;
    cnt_d    = (Stall & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctrl_q   <= '0;
      data_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end
  assign ExValid       = ctrl_q.valid;
  assign ExRegDst      = ctrl_q.regdst;
  assign ExMemToReg    = ctrl_q.memtoreg;
  assign ExRegWrite    = ctrl_q.regwrite;
  assign ExMemRead     = ctrl_q.memread;
  assign ExMemWrite    = ctrl_q.memwrite;
  assign ExALUSrc      = ctrl_q.alusrc;
  assign ExALUOp       = ctrl_q.aluop;
  assign ExRs          = ctrl_q.rs;
  assign ExRt          = ctrl_q.rt;
  assign ExRd          = ctrl_q.rd;
  assign {ExRD1, ExRD2, ExImm, ExPCPlus4} = data_q;
  assign IllegalSticky = sticky_q;
  assign StallCount    = cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: randomized self-checking bench for id_ex_stage_reg against a behavioural model
module tb_id_ex_stage_reg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  typedef struct packed {
    logic        valid;
    logic [1:0]  regdst;
    logic [1:0]  memtoreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        alusrc;
    logic [3:0]  aluop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } ex_t;
  logic clk = 1'b0;
  logic rst, flush, ext_stall;
  ex_t id, act, m_ex, saved;
  logic stall, sticky;
  logic [CNT_W-1:0] count;
  logic m_sticky;
  int m_cnt;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Reset(rst),
    .IdValid(id.valid), .IdRegDst(id.regdst), .IdMemToReg(id.memtoreg), .IdRegWrite(id.regwrite),
    .IdMemRead(id.memread), .IdMemWrite(id.memwrite), .IdALUSrc(id.alusrc), .IdALUOp(id.aluop),
    .IdRs(id.rs), .IdRt(id.rt), .IdRd(id.rd),
    .IdRD1(id.rd1), .IdRD2(id.rd2), .IdImm(id.imm), .IdPCPlus4(id.pc4),
    .Flush(flush), .ExtStall(ext_stall),
    .ExValid(act.valid), .ExRegDst(act.regdst), .ExMemToReg(act.memtoreg), .ExRegWrite(act.regwrite),
    .ExMemRead(act.memread), .ExMemWrite(act.memwrite), .ExALUSrc(act.alusrc), .ExALUOp(act.aluop),
    .ExRs(act.rs), .ExRt(act.rt), .ExRd(act.rd),
    .ExRD1(act.rd1), .ExRD2(act.rd2), .ExImm(act.imm), .ExPCPlus4(act.pc4),
    .Stall(stall), .IllegalSticky(sticky), .StallCount(count)
  );
  function automatic ex_t rand_id();
    ex_t r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    r.valid = 1'b1;
    r.regdst = 2'($urandom_range(0, 2));
    return r;
  endfunction
  function automatic ex_t lw(input logic [4:0] rt);
    ex_t r;
    r = rand_id();
    r.memread = 1'b1;
    r.regwrite = 1'b1;
    r.memwrite = 1'b0;
    r.regdst = 2'd0;
    r.rt = rt;
    return r;
  endfunction
  function automatic logic m_stall();
    logic use_hit;
    use_hit = m_ex.valid && m_ex.memread && m_ex.rt != 0 && id.valid && (m_ex.rt == id.rs || m_ex.rt == id.rt);
    return use_hit && !flush && !ext_stall;
  endfunction
  task automatic tick();
    logic s;
    s = m_stall();
    if (rst) begin
      m_ex = '0;
      m_sticky = 1'b0;
      m_cnt = 0;
    end else if (flush) m_ex = '0;
    else if (!ext_stall) begin
      if (s) begin
        m_ex = '0;
        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end else if (!id.valid) m_ex = '0;
      else if (id.regdst == 2'd3) begin
        m_ex = '0;
        m_sticky = 1'b1;
      end else m_ex = id;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; ext_stall = 1'b1; id = rand_id();
    tick(); tick();
    total++; if (act !== '0) begin bad++; $display("FAIL reset_ex: got=%h want=0", act); end
    total++; if (sticky !== 1'b0 || count !== '0) begin bad++; $display("FAIL reset_cnt: got=%b/%0d want=0/0", sticky, count); end
    rst = 1'b0; flush = 1'b0; ext_stall = 1'b0;
  endtask
  task automatic test_load_use();
    ex_t add_i;
    id = lw(5'd8); tick();
    add_i = rand_id(); add_i.memread = 1'b0; add_i.rs = 5'd8; add_i.rt = 5'd9; add_i.regdst = 2'd1;
    id = add_i; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got=%b want=1", stall); end
    tick();
    total++; if (act.valid !== 1'b0 || act !== m_ex) begin bad++; $display("FAIL lu_bubble: got=%h want=%h", act, m_ex); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_unstall: got=%b want=0", stall); end
    tick();
    total++; if (act !== add_i) begin bad++; $display("FAIL lu_load: got=%h want=%h", act, add_i); end
    total++; if (count !== CNT_W'(1) || count !== CNT_W'(m_cnt)) begin bad++; $display("FAIL lu_count: got=%0d want=1", count); end
  endtask
  task automatic test_zero_reg();
    int c0;
    c0 = m_cnt;
    id = lw(5'd0); tick();
    id = rand_id(); id.rs = 5'd0; id.rt = 5'd0; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL zero_stall: got=%b want=0", stall); end
    tick();
    total++; if (act !== id || act.valid !== 1'b1) begin bad++; $display("FAIL zero_load: got=%h want=%h", act, id); end
    total++; if (count !== CNT_W'(c0)) begin bad++; $display("FAIL zero_count: got=%0d want=%0d", count, c0); end
  endtask
  task automatic test_hazard_flush();
    int c0;
    c0 = m_cnt;
    id = lw(5'd5); tick();
    id = rand_id(); id.rs = 5'd5; flush = 1'b1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hf_stall: got=%b want=0", stall); end
    tick();
    flush = 1'b0;
    total++; if (act !== '0) begin bad++; $display("FAIL hf_bubble: got=%h want=0", act); end
    total++; if (count !== CNT_W'(c0)) begin bad++; $display("FAIL hf_count: got=%0d want=%0d", count, c0); end
  endtask
  task automatic test_ext_stall();
    id = lw(5'd7); tick();
    saved = id;
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id = rand_id(); id.rs = 5'd7; #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL es_stall%0d: got=%b want=0", i, stall); end
      tick();
      total++; if (act !== saved) begin bad++; $display("FAIL es_hold%0d: got=%h want=%h", i, act, saved); end
    end
    ext_stall = 1'b0;
  endtask
  task automatic test_illegal();
    id = rand_id(); id.regdst = 2'd3; id.memread = 1'b0; tick();
    total++; if (act.valid !== 1'b0 || sticky !== 1'b1) begin bad++; $display("FAIL ill_trap: got=%b/%b want=0/1", act.valid, sticky); end
    for (int i = 0; i < 4; i++) begin id = rand_id(); tick(); end
    total++; if (sticky !== 1'b1 || act !== m_ex) begin bad++; $display("FAIL ill_hold: got=%b want=1", sticky); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (sticky !== 1'b0) begin bad++; $display("FAIL ill_clear: got=%b want=0", sticky); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id = {$urandom, $urandom, $urandom, $urandom, $urandom};
      id.rs = 5'($urandom_range(0, 3)); id.rt = 5'($urandom_range(0, 3));
      id.valid = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 9) != 0 && id.regdst == 2'd3) id.regdst = 2'd1;
      flush = ($urandom_range(0, 7) == 0);
      ext_stall = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      total++; if (stall !== m_stall()) begin bad++; $display("FAIL rnd_stall%0d: got=%b want=%b", i, stall, m_stall()); end
      tick();
      total++; if (act !== m_ex) begin bad++; $display("FAIL rnd_ex%0d: got=%h want=%h", i, act, m_ex); end
      total++; if (sticky !== m_sticky || count !== CNT_W'(m_cnt)) begin bad++; $display("FAIL rnd_stat%0d: got=%b/%0d want=%b/%0d", i, sticky, count, m_sticky, m_cnt); end
      total++; if (act.valid && act.regdst == 2'd3) begin bad++; $display("FAIL rnd_regdst%0d: got=3 want=0..2", i); end
    end
    rst = 1'b0; flush = 1'b0; ext_stall = 1'b0;
  endtask
  task automatic test_saturation();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      id = lw(5'd8); tick();
      id = rand_id(); id.rt = 5'd8; tick();
    end
    total++; if (count !== CNT_W'(CNT_MAX) || m_cnt != CNT_MAX) begin bad++; $display("FAIL sat_count: got=%0d want=%0d", count, CNT_MAX); end
    id = lw(5'd8); tick();
    id = rand_id(); id.rs = 5'd8; flush = 1'b1; ext_stall = 1'b1; rst = 1'b1; tick();
    total++; if (act !== '0 || sticky !== 1'b0 || count !== '0) begin bad++; $display("FAIL rst_mid: got=%h/%0d want=0/0", act, count); end
    rst = 1'b0; flush = 1'b0; ext_stall = 1'b0; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall: got=%b want=0", stall); end
  endtask
  initial begin
    m_ex = '0; m_sticky = 1'b0; m_cnt = 0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_hazard_flush();
    test_ext_stall();
    test_illegal();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath word width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have ports Clk in 1 (single clock), then Reset in 1 (synchronous, active-high).
REQ-004 SHALL have inputs IdValid 1, IdRegDst 2 (0=rt, 1=rd, 2=$31, 3=illegal), IdMemToReg 2, IdRegWrite 1, IdMemRead 1, IdMemWrite 1, IdALUSrc 1, IdALUOp 4.
REQ-005 SHALL have inputs IdRs, IdRt, IdRd 5 each; IdRD1, IdRD2, IdImm, IdPCPlus4 DATA_W each.
REQ-006 SHALL have inputs Flush 1 (branch taken, kill ID instruction) and ExtStall 1 (downstream hold).
REQ-007 SHALL have outputs Ex* mirroring every Id* input (registered), plus Stall 1 (to PC and IF/ID), IllegalSticky 1 and StallCount CNT_W.

Function
REQ-008 SHALL update only on rising Clk; priority Reset > Flush > ExtStall > load-use bubble > normal load.
REQ-009 Normal load SHALL capture all Id* into Ex* with one-cycle latency.
REQ-010 Load-use hazard SHALL be detected when ExValid & ExMemRead & ExRt!=0 & IdValid & (ExRt==IdRs | ExRt==IdRt).
REQ-011 Stall output SHALL be combinational, high exactly while the hazard condition holds and neither Flush nor ExtStall is high.
REQ-012 On a hazard cycle the stage SHALL load a bubble: ExValid, ExRegWrite, ExMemRead, ExMemWrite = 0; other Ex* fields don't-care but SHALL be 0.
REQ-013 After one bubble the hazard clears (ExMemRead=0) and the held ID instruction SHALL load on the next edge; total penalty exactly 1 cycle.
REQ-014 Flush SHALL load a bubble regardless of hazard or ExtStall; Stall SHALL be low during Flush.
REQ-015 ExtStall (without Flush) SHALL hold every Ex* register unchanged; Stall SHALL be low (ExtStall is distributed externally).
REQ-016 IdRegDst==3 with IdValid on a normal-load cycle SHALL load a bubble instead and set IllegalSticky.
REQ-017 IllegalSticky SHALL stay high until Reset.
REQ-018 StallCount SHALL increment by 1 on each edge where Stall is high, saturating at all-ones (no wrap).
REQ-019 IdValid=0 SHALL never raise Stall and SHALL load a bubble.
REQ-020 ExRegDst SHALL only ever carry 0, 1 or 2 when ExValid=1 (it drives the downstream 2-bit register-destination select).

Reset
REQ-021 Reset SHALL be sampled only at Clk rising edge; all Ex* outputs, IllegalSticky and StallCount SHALL be 0 after that edge.
REQ-022 Reset mid-stall SHALL clear the bubble/hold state; Stall SHALL be low in the cycle after reset as ExValid=0.
REQ-023 Reset SHALL override Flush, ExtStall and hazard in the same cycle.

Structure
REQ-024 RegDst encodings (RT, RD, RA, ILLEGAL), MemToReg encodings, ALUOp width and register-number width SHALL live in a shared package.
REQ-025 Load-use detection SHALL be a sub-module hazard_detect (pure combinational, inputs Ex/Id fields, output hazard).
REQ-026 Pipeline fields SHALL be held in one register set; no other sub-modules.

Verification
REQ-027 lw ExRt=8 then IdRs=8 -> Stall=1 for 1 cycle, ExValid=0 bubble, then add loads; StallCount=1.
REQ-028 lw ExRt=0, IdRs=0 -> Stall=0, no bubble, StallCount=0.
REQ-029 Hazard plus Flush same cycle -> Stall=0, bubble loaded, StallCount unchanged.
REQ-030 ExtStall high 3 cycles with valid Ex contents -> Ex* unchanged across all 3 edges, Stall=0.
REQ-031 IdRegDst=3, IdValid=1 -> ExValid=0 next edge, IllegalSticky=1, held until Reset.
REQ-032 Force 65537 hazard cycles (CNT_W=16) -> StallCount=16'hFFFF; Reset mid-hazard -> all outputs 0 next edge.
